sigma_delta_modulator: RTL and testbench



---
 rtl/sd_pkg.sv | 23 ++
 rtl/sd_mod1_core.sv | 33 +++
 rtl/sigma_delta_modulator.sv | 74 +++++++
 tb/tb_sigma_delta_modulator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants and width helpers for the delta-sigma modulator
package sd_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int OSR_DEF     = 64;
    localparam int ACC_W_DEF   = DATA_W_DEF + 2;
    localparam int PHASE_W_DEF = $clog2(OSR_DEF);

    // Full scale: the magnitude the 1-bit output represents.
    function automatic int fs_of(input int data_w);
        return 1 << (data_w - 1);
    endfunction

    // Two guard bits hold the worst-case swing of acc + x - (+/-FS).
    function automatic int acc_w_of(input int data_w);
        return data_w + 2;
    endfunction

    function automatic int phase_w_of(input int osr);
        return $clog2(osr);
    endfunction

endpackage

// File: rtl/sd_mod1_core.sv
// rtl/sd_mod1_core.sv - first-order accumulator, 1-bit quantizer and feedback
module sd_mod1_core
    import sd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    output logic              y
);

    localparam int ACC_W = acc_w_of(DATA_W);
    localparam logic signed [ACC_W-1:0] FS = ACC_W'(fs_of(DATA_W));

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] fb;

    assign x_ext = {{2{x[DATA_W-1]}}, x};
    // The quantizer looks only at the registered accumulator, so y is glitch-free.
    assign y     = ~acc[ACC_W-1];
    assign fb    = y ? FS : -FS;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc + x_ext - fb;
        end
    end

endmodule

// File: rtl/sigma_delta_modulator.sv
// rtl/sigma_delta_modulator.sv - PCM-to-bitstream modulator with frame-rate sample intake
module sigma_delta_modulator
    import sd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OSR    = OSR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              bit_out,
    output logic              frame_strobe,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam int PHASE_W = phase_w_of(OSR);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(OSR - 1);

    logic [PHASE_W-1:0] phase;
    logic               boundary;
    logic               xfer;
    logic               buf_full;
    logic [DATA_W-1:0]  buf_data;
    logic [DATA_W-1:0]  active;
    logic               underrun_set;

    assign boundary     = (phase == LAST_PHASE);
    assign sample_ready = !buf_full && !rst;
    assign xfer         = sample_valid && sample_ready;
    assign underrun_set = boundary && !buf_full && !xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= '0;
            buf_full     <= 1'b0;
            buf_data     <= '0;
            active       <= '0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            // OSR is a power of two, so the counter wraps on its own.
            phase        <= phase + 1'b1;
            frame_strobe <= 1'b0;
            underrun     <= underrun_set || (underrun && !underrun_clr);
            if (boundary) begin
                if (buf_full) begin
                    active       <= buf_data;
                    buf_full     <= 1'b0;
                    frame_strobe <= 1'b1;
                end else if (xfer) begin
                    // Empty buffer at the boundary: the sample goes straight to active.
                    active       <= sample_in;
                    frame_strobe <= 1'b1;
                end
            end else if (xfer) begin
                buf_data <= sample_in;
                buf_full <= 1'b1;
            end
        end
    end

    sd_mod1_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .clk(clk),
        .rst(rst),
        .x  (active),
        .y  (bit_out)
    );

endmodule

// File: tb/tb_sigma_delta_modulator.sv
// tb/tb_sigma_delta_modulator.sv - scoreboard bench for sigma_delta_modulator
module tb_sigma_delta_modulator;

    localparam int DATA_W = 16;
    localparam int OSR    = 64;
    localparam int FS     = 32768;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic signed [DATA_W-1:0] sample_in = '0;
    logic                     sample_valid = 1'b0;
    logic                     sample_ready;
    logic                     bit_out;
    logic                     frame_strobe;
    logic                     underrun;
    logic                     underrun_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference state: expected accumulator, active sample, phase and pending samples.
    int m_acc    = 0;
    int m_active = 0;
    int m_phase  = 0;
    int q[$];

    always #5 clk = ~clk;

    sigma_delta_modulator #(
        .DATA_W(DATA_W),
        .OSR   (OSR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .bit_out     (bit_out),
        .frame_strobe(frame_strobe),
        .underrun    (underrun),
        .underrun_clr(underrun_clr)
    );

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle compare bit_out to the reference, pop on frame_strobe.
    initial begin
        forever begin
            @(negedge clk);
            chk("bit_out", bit_out, m_acc >= 0);
            if (frame_strobe === 1'b1) begin
                chk("strobe_phase", m_phase, 0);
                chk("strobe_has_sample", q.size() > 0, 1);
                if (q.size() > 0) m_active = q.pop_front();
            end
            if (rst) begin
                m_acc    = 0;
                m_active = 0;
                m_phase  = 0;
                q.delete();
            end else begin
                if (sample_valid && sample_ready) q.push_back(int'(sample_in));
                m_acc   = m_acc + m_active - ((m_acc >= 0) ? FS : -FS);
                m_phase = (m_phase + 1) % OSR;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Returns just after the rising edge that starts a cycle with phase p.
    task automatic wait_phase(input int p);
        bit hit = 1'b0;
        for (int i = 0; i < 2 * OSR + 4 && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = (m_phase == p);
        end
        chk("wait_phase", hit, 1);
    endtask

    task automatic send(input int x);
        bit hit = 1'b0;
        @(posedge clk);
        #1;
        sample_in    = DATA_W'(x);
        sample_valid = 1'b1;
        for (int i = 0; i < 3 * OSR && !hit; i++) begin
            @(negedge clk);
            hit = sample_ready;
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        chk("send_accept", hit, 1);
    endtask

    task automatic count_frame(output int ones, output bit strobe0);
        wait_phase(0);
        ones    = 0;
        strobe0 = 1'b0;
        for (int i = 0; i < OSR; i++) begin
            @(negedge clk);
            if (i == 0) strobe0 = frame_strobe;
            ones += int'(bit_out);
        end
    endtask

    task automatic frame_with(input int next_x, input string name, input int lo, input int hi);
        int o;
        bit s;
        fork
            count_frame(o, s);
            send(next_x);
        join
        chk({name, "_strobe"}, s, 1);
        checks++;
        if (o < lo || o > hi) begin
            errors++;
            $display("FAIL %s_ones actual=%0d expected=%0d..%0d", name, o, lo, hi);
        end
    endtask

    task automatic clr_pulse();
        underrun_clr = 1'b1;
        @(posedge clk);
        #1;
        underrun_clr = 1'b0;
    endtask

    initial begin
        int bp[4] = '{1000, -2000, 3000, -4000};
        bit hit;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bit_out", bit_out, 1);
        chk("rst_ready", sample_ready, 0);
        chk("rst_strobe", frame_strobe, 0);
        chk("rst_underrun", underrun, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle, x=0: 1,0,1,0 from the first cycle out of reset.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_alternate", bit_out, (i % 2 == 0) ? 1 : 0);
        end
        wait_phase(63);
        @(negedge clk);
        chk("underrun_before_boundary", underrun, 0);
        @(negedge clk);
        chk("underrun_first_boundary", underrun, 1);
        chk("no_strobe_on_underrun", frame_strobe, 0);

        send(16384);
        clr_pulse();
        @(negedge clk);
        chk("underrun_cleared", underrun, 0);

        frame_with(16384,  "f_half_a", 48, 48);
        frame_with(-32768, "f_half_b", 48, 48);
        frame_with(32767,  "f_negfs",  1, 1);
        chk("acc_neg_settle", dut.u_core.acc, -65536);
        frame_with(32767,  "f_posfs_a", 62, 62);
        frame_with(0,      "f_posfs_b", 63, 64);
        chk("underrun_fed_frames", underrun, 0);

        // Backpressure: valid held high, new value after each accept.
        wait_phase(5);
        sample_in    = DATA_W'(bp[0]);
        sample_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            hit = 1'b0;
            for (int i = 0; i < 3 * OSR && !hit; i++) begin
                @(negedge clk);
                hit = sample_ready;
            end
            chk("bp_accept", hit, 1);
            @(posedge clk);
            #1;
            if (k < 3) sample_in = DATA_W'(bp[k + 1]);
            else sample_valid = 1'b0;
            if (k == 0) begin
                @(negedge clk);
                chk("bp_ready_low", sample_ready, 0);
            end
        end
        wait_phase(63);
        wait_phase(2);
        chk("queue_drained", q.size(), 0);
        chk("bp_no_underrun", underrun, 0);

        // Bypass: sample offered only in the boundary cycle.
        wait_phase(63);
        wait_phase(10);
        chk("underrun_after_drain", underrun, 1);
        clr_pulse();
        @(negedge clk);
        chk("clr_mid_frame", underrun, 0);
        wait_phase(63);
        sample_in    = DATA_W'(12345);
        sample_valid = 1'b1;
        @(negedge clk);
        chk("bypass_ready", sample_ready, 1);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        @(negedge clk);
        chk("bypass_strobe", frame_strobe, 1);
        chk("bypass_no_underrun", underrun, 0);

        wait_phase(63);
        @(negedge clk);
        @(negedge clk);
        chk("skip_underrun", underrun, 1);
        chk("skip_no_strobe", frame_strobe, 0);
        wait_phase(10);
        clr_pulse();
        @(negedge clk);
        chk("clr_nonboundary", underrun, 0);
        wait_phase(63);
        clr_pulse();
        @(negedge clk);
        chk("set_beats_clr", underrun, 1);
        wait_phase(1);
        clr_pulse();
        @(negedge clk);
        chk("clr_again", underrun, 0);

        // Reset mid-frame with a full buffer.
        send(7777);
        wait_phase(30);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_phase", dut.phase, 0);
        chk("midrst_acc", dut.u_core.acc, 0);
        chk("midrst_buf_full", dut.buf_full, 0);
        chk("midrst_bit_out", bit_out, 1);
        chk("midrst_ready", sample_ready, 0);
        chk("midrst_strobe", frame_strobe, 0);
        chk("midrst_underrun", underrun, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_ready_hold", sample_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", sample_ready, 1);
        wait_phase(63);
        @(negedge clk);
        @(negedge clk);
        chk("discarded_underrun", underrun, 1);
        chk("discarded_no_strobe", frame_strobe, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
